spdif_sample_sched: RTL and testbench



---
 rtl/spdif_sample_sched_pkg.sv | 18 +
 rtl/spdif_sample_sched_if.sv | 33 +++
 rtl/spdif_sample_fifo.sv | 62 ++++++
 rtl/spdif_sample_sched.sv | 99 +++++++++
 tb/tb_spdif_sample_sched.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/spdif_sample_sched_pkg.sv
// Shared audio definitions: scheduler states, stereo frame layout and the silence word.
package spdif_sample_sched_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPrime = 2'd1,
    StRun   = 2'd2
  } sched_state_e;

  // Stereo frame as seen by the transmitter: right channel in the upper half.
  typedef struct packed {
    logic [15:0] r;
    logic [15:0] l;
  } frame_t;

  localparam frame_t Silence = 32'h0;

endpackage

// File: rtl/spdif_sample_sched_if.sv
// Producer stream, transmitter request and status signals of the sample scheduler.
interface spdif_sample_sched_if #(
  parameter int unsigned DEPTH = 8
);
  import spdif_sample_sched_pkg::*;

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic          en_i;
  logic          mute_i;
  frame_t        in_data_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic          sample_req_i;
  frame_t        sample_o;
  logic          run_o;
  logic [LW-1:0] level_o;
  logic          underrun_o;
  logic [7:0]    underrun_cnt_o;

  // Driver side: producer, transmitter and control.
  modport master (
    output en_i, mute_i, in_data_i, in_valid_i, sample_req_i,
    input  in_ready_o, sample_o, run_o, level_o, underrun_o, underrun_cnt_o
  );

  // Scheduler side.
  modport slave (
    input  en_i, mute_i, in_data_i, in_valid_i, sample_req_i,
    output in_ready_o, sample_o, run_o, level_o, underrun_o, underrun_cnt_o
  );

endinterface

// File: rtl/spdif_sample_fifo.sv
// Synchronous DEPTH x 32 frame FIFO with occupancy count and synchronous clear.
module spdif_sample_fifo
  import spdif_sample_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   clr,
  input  logic                   push,
  input  logic                   pop,
  input  frame_t                 wdata,
  output frame_t                 rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [AW-1:0] PtrOne = AW'(1);
  localparam logic [LW-1:0] LvlOne = LW'(1);

  frame_t          mem [DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [LW-1:0]   level_q;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (push && !clr) mem[wptr_q] <= wdata;
  end

  // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else if (clr) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PtrOne;
      if (pop)  rptr_q <= rptr_q + PtrOne;
      unique case ({push, pop})
        2'b10:   level_q <= level_q + LvlOne;
        2'b01:   level_q <= level_q - LvlOne;
        default: level_q <= level_q;
      endcase
    end
  end

  // Head of queue and occupancy flags.
  always_comb begin
    rdata = mem[rptr_q];
    full  = (level_q == LW'(DEPTH));
    empty = (level_q == '0);
    level = level_q;
  end

endmodule

// File: rtl/spdif_sample_sched.sv
// Sample scheduler: primes a frame FIFO, answers transmitter requests, tracks underruns.
module spdif_sample_sched
  import spdif_sample_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PRIME = 4
) (
  input logic                  clk_i,
  input logic                  rst_n_i,
  spdif_sample_sched_if.slave  bus
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  sched_state_e  state_q, state_d;
  frame_t        sample_q;
  logic          underrun_q;
  logic [7:0]    underrun_cnt_q;

  frame_t        head;
  logic          full, empty;
  logic [LW-1:0] level;
  logic          in_ready, push, pop, underrun_evt, run;

  spdif_sample_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr     (~bus.en_i),
    .push    (push),
    .pop     (pop),
    .wdata   (bus.in_data_i),
    .rdata   (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Next state; PRIME exit is judged on the registered level.
  always_comb begin
    state_d = state_q;
    if (!bus.en_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  state_d = StPrime;
        StPrime: if (level >= LW'(PRIME)) state_d = StRun;
        StRun:   if (underrun_evt) state_d = StPrime;
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM outputs and FIFO strobes; a same-cycle push never rescues an empty-FIFO request.
  always_comb begin
    run          = (state_q == StRun);
    in_ready     = bus.en_i && !full && (state_q != StIdle);
    push         = bus.in_valid_i && in_ready;
    pop          = bus.en_i && run && bus.sample_req_i && !empty;
    underrun_evt = bus.en_i && run && bus.sample_req_i && empty;
  end

  // Output word, underrun pulse and saturating underrun counter.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sample_q       <= Silence;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= 8'd0;
    end else begin
      underrun_q <= underrun_evt;
      if (!bus.en_i) begin
        sample_q <= Silence;
      end else if (pop) begin
        sample_q <= bus.mute_i ? Silence : head;
      end else if (underrun_evt) begin
        sample_q <= Silence;
      end
      if (underrun_evt && underrun_cnt_q != 8'hFF) underrun_cnt_q <= underrun_cnt_q + 8'd1;
    end
  end

  // Drive the interface.
  always_comb begin
    bus.in_ready_o     = in_ready;
    bus.sample_o       = sample_q;
    bus.run_o          = run;
    bus.level_o        = level;
    bus.underrun_o     = underrun_q;
    bus.underrun_cnt_o = underrun_cnt_q;
  end

endmodule

// File: tb/tb_spdif_sample_sched.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_spdif_sample_sched;
  import spdif_sample_sched_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned PRIME = 4;
  localparam int MIdle  = 0;
  localparam int MPrime = 1;
  localparam int MRun   = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  // Reference model: frame queue, mode, output word, pulse and total underruns.
  logic [31:0] m_q[$];
  int          m_mode;
  logic [31:0] m_smp;
  bit          m_ur;
  int          m_total;

  spdif_sample_sched_if #(.DEPTH(DEPTH)) bif ();

  spdif_sample_sched #(
    .DEPTH (DEPTH),
    .PRIME (PRIME)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_mode  = MIdle;
    m_smp   = 32'h0;
    m_ur    = 1'b0;
    m_total = 0;
  endtask

  task automatic chk_all();
    chk("sample", bif.sample_o, m_smp);
    chk("run", {31'd0, bif.run_o}, {31'd0, m_mode == MRun});
    chk("level", {28'd0, bif.level_o}, m_q.size());
    chk("underrun", {31'd0, bif.underrun_o}, {31'd0, m_ur});
    chk("ur_cnt", {24'd0, bif.underrun_cnt_o}, (m_total > 255) ? 255 : m_total);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sample"}, bif.sample_o, 32'h0);
    chk({tag, "_ready"}, {31'd0, bif.in_ready_o}, 32'd0);
    chk({tag, "_run"}, {31'd0, bif.run_o}, 32'd0);
    chk({tag, "_level"}, {28'd0, bif.level_o}, 32'd0);
    chk({tag, "_underrun"}, {31'd0, bif.underrun_o}, 32'd0);
    chk({tag, "_cnt"}, {24'd0, bif.underrun_cnt_o}, 32'd0);
  endtask

  // One clock cycle of stimulus; the model advances from the pre-edge view of the queue.
  task automatic step(input bit en, input bit mute, input bit valid, input logic [31:0] data,
                      input bit req);
    bit          rdy;
    bit          push;
    int          sz;
    logic [31:0] f;
    bif.en_i         = en;
    bif.mute_i       = mute;
    bif.in_valid_i   = valid;
    bif.in_data_i    = data;
    bif.sample_req_i = req;
    #1;
    rdy = en && (m_mode != MIdle) && (m_q.size() < DEPTH);
    chk("in_ready", {31'd0, bif.in_ready_o}, {31'd0, rdy});
    push = valid && rdy;
    sz   = m_q.size();
    @(posedge clk);
    #1;
    m_ur = 1'b0;
    if (!en) begin
      m_q.delete();
      m_mode = MIdle;
      m_smp  = 32'h0;
    end else begin
      case (m_mode)
        MIdle:  m_mode = MPrime;
        MPrime: if (sz >= PRIME) m_mode = MRun;
        default: begin
          if (req) begin
            if (sz > 0) begin
              f     = m_q.pop_front();
              m_smp = mute ? 32'h0 : f;
            end else begin
              m_smp = 32'h0;
              m_ur  = 1'b1;
              m_total++;
              m_mode = MPrime;
            end
          end
        end
      endcase
      if (push) m_q.push_back(data);
    end
    chk_all();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_reset();
    bif.en_i         = 1'b0;
    bif.mute_i       = 1'b0;
    bif.in_valid_i   = 1'b0;
    bif.in_data_i    = '0;
    bif.sample_req_i = 1'b0;
    rst_n            = 1'b0;
    #8;
    chk_reset_vals("rst");
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Prime with four frames, then drain them in order.
    step(1, 0, 0, 32'h0, 0);
    for (int i = 1; i <= 4; i++) step(1, 0, 1, {i[15:0], i[15:0]}, 0);
    step(1, 0, 0, 32'h0, 0);
    chk("entered_run", {31'd0, bif.run_o}, 32'd1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 32'h0, 1);
    chk("fourth_frame", bif.sample_o, 32'h0004_0004);

    // Request on empty FIFO: underrun, back to PRIME.
    step(1, 0, 0, 32'h0, 1);
    chk("underrun_pulse", {31'd0, bif.underrun_o}, 32'd1);
    step(1, 0, 0, 32'h0, 0);

    // Fill to DEPTH, then request plus valid while full: pop only.
    for (int i = 5; i <= 12; i++) step(1, 0, 1, {i[15:0], i[15:0]}, 0);
    chk("full_level", {28'd0, bif.level_o}, 32'd8);
    step(1, 0, 1, 32'hDEAD_BEEF, 1);
    chk("full_pop_level", {28'd0, bif.level_o}, 32'd7);

    // Mute three of five queued frames, then unmute.
    step(1, 0, 0, 32'h0, 1);
    step(1, 0, 0, 32'h0, 1);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 32'h0, 1);
    chk("mute_level", {28'd0, bif.level_o}, 32'd2);
    step(1, 0, 0, 32'h0, 1);
    chk("unmute_frame", bif.sample_o, 32'h000B_000B);

    // Refill to six, then drop enable.
    for (int i = 0; i < 5; i++) step(1, 0, 1, 32'hA5A5_0000 + i, 0);
    step(0, 0, 1, 32'h1234_5678, 1);
    chk("en_drop_level", {28'd0, bif.level_o}, 32'd0);

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      step($urandom_range(0, 15) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
           $urandom, $urandom_range(0, 2) == 0);
    end

    // Drive repeated underruns until the counter must have saturated.
    for (int n = 0; n < 6000 && m_total < 300; n++) begin
      step(1, 0, m_mode != MRun, $urandom, m_mode == MRun);
    end
    chk("sat_cnt", {24'd0, bif.underrun_cnt_o}, 32'd255);

    // Queue some frames, then assert reset between clock edges.
    for (int i = 0; i < 3; i++) step(1, 0, 1, $urandom, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("async");
    @(posedge clk);
    #3 rst_n = 1'b1;
    model_reset();
    bif.en_i = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) step(1, 0, 1, 32'h0F0F_0000 + i, 0);
    step(1, 0, 0, 32'h0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
